// File: rtl/cs_neighbor_avg.sv
// cs_neighbor_avg: accumulates N left then N up neighbour samples of one block
// and produces rounded left-column, up-row and DC averages.
// Ports:
//   clk, reset        - rising-edge clock, asynchronous active-high reset
//   start, flush      - begin a block (IDLE only) / synchronous abort
//   sample_in/valid   - neighbour sample stream; sample_ready is state-decoded
//   busy              - block in progress
//   avg_valid         - one-cycle pulse when the averages are updated
//   avg_y_*_out       - registered averages, held until the next update
module cs_neighbor_avg #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned BLK_LOG2   = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] sample_in,
    input  logic                  sample_valid,
    output logic                  sample_ready,
    output logic                  busy,
    output logic                  avg_valid,
    output logic [DATA_WIDTH-1:0] avg_y_left_out,
    output logic [DATA_WIDTH-1:0] avg_y_up_out,
    output logic [DATA_WIDTH-1:0] avg_y_dc_out
);

    localparam int unsigned SUM_W = DATA_WIDTH + BLK_LOG2;
    localparam int unsigned DC_W  = SUM_W + 1;
    localparam logic [SUM_W-1:0]    RND_EDGE = SUM_W'(1) << (BLK_LOG2 - 1);
    localparam logic [DC_W-1:0]     RND_DC   = DC_W'(1) << BLK_LOG2;
    localparam logic [BLK_LOG2-1:0] CNT_LAST = '1;

    typedef enum logic [2:0] {
        IDLE,
        ACC_LEFT,
        ACC_UP,
        CALC,
        DONE
    } state_t;

    state_t                state_q, state_d;
    logic [BLK_LOG2-1:0]   cnt_q, cnt_d;
    logic [SUM_W-1:0]      sum_left_q, sum_left_d;
    logic [SUM_W-1:0]      sum_up_q, sum_up_d;
    logic [DATA_WIDTH-1:0] avg_left_q, avg_left_d;
    logic [DATA_WIDTH-1:0] avg_up_q, avg_up_d;
    logic [DATA_WIDTH-1:0] avg_dc_q, avg_dc_d;
    logic                  sample_ready_q, sample_ready_d;
    logic                  busy_q, busy_d;
    logic                  avg_valid_q, avg_valid_d;

    logic                  accept;
    logic [SUM_W-1:0]      left_rnd;
    logic [SUM_W-1:0]      up_rnd;
    logic [DC_W-1:0]       dc_rnd;

    // Rounded means; the rounding offset cannot carry out of SUM_W bits
    always_comb begin
        left_rnd = sum_left_q + RND_EDGE;
        up_rnd   = sum_up_q + RND_EDGE;
        dc_rnd   = DC_W'(sum_left_q) + DC_W'(sum_up_q) + RND_DC;
    end

    // sample_ready is a flop, so acceptance has no path from sample_valid to ready
    assign accept = sample_valid & sample_ready_q;

    // Next-state, accumulation and output-register inputs
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sum_left_d = sum_left_q;
        sum_up_d   = sum_up_q;
        avg_left_d = avg_left_q;
        avg_up_d   = avg_up_q;
        avg_dc_d   = avg_dc_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = ACC_LEFT;
                    cnt_d      = '0;
                    sum_left_d = '0;
                    sum_up_d   = '0;
                end
            end
            ACC_LEFT: begin
                if (accept) begin
                    sum_left_d = sum_left_q + SUM_W'(sample_in);
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = ACC_UP;
                    end else begin
                        cnt_d = cnt_q + BLK_LOG2'(1);
                    end
                end
            end
            ACC_UP: begin
                if (accept) begin
                    sum_up_d = sum_up_q + SUM_W'(sample_in);
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = CALC;
                    end else begin
                        cnt_d = cnt_q + BLK_LOG2'(1);
                    end
                end
            end
            CALC: begin
                avg_left_d = DATA_WIDTH'(left_rnd >> BLK_LOG2);
                avg_up_d   = DATA_WIDTH'(up_rnd >> BLK_LOG2);
                avg_dc_d   = DATA_WIDTH'(dc_rnd >> (BLK_LOG2 + 1));
                state_d    = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Abort overrides everything, including a same-cycle start or accept
        if (flush) begin
            state_d    = IDLE;
            cnt_d      = '0;
            sum_left_d = '0;
            sum_up_d   = '0;
            avg_left_d = avg_left_q;
            avg_up_d   = avg_up_q;
            avg_dc_d   = avg_dc_q;
        end

        sample_ready_d = (state_d == ACC_LEFT) || (state_d == ACC_UP);
        busy_d         = (state_d != IDLE);
        avg_valid_d    = (state_d == DONE);
    end

    // State and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            sum_left_q     <= '0;
            sum_up_q       <= '0;
            avg_left_q     <= '0;
            avg_up_q       <= '0;
            avg_dc_q       <= '0;
            sample_ready_q <= 1'b0;
            busy_q         <= 1'b0;
            avg_valid_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            sum_left_q     <= sum_left_d;
            sum_up_q       <= sum_up_d;
            avg_left_q     <= avg_left_d;
            avg_up_q       <= avg_up_d;
            avg_dc_q       <= avg_dc_d;
            sample_ready_q <= sample_ready_d;
            busy_q         <= busy_d;
            avg_valid_q    <= avg_valid_d;
        end
    end

    assign sample_ready   = sample_ready_q;
    assign busy           = busy_q;
    assign avg_valid      = avg_valid_q;
    assign avg_y_left_out = avg_left_q;
    assign avg_y_up_out   = avg_up_q;
    assign avg_y_dc_out   = avg_dc_q;

endmodule

// File: tb/tb_cs_neighbor_avg.sv
// tb_cs_neighbor_avg: directed vectors with hand-computed averages for
// cs_neighbor_avg at DATA_WIDTH=8, BLK_LOG2=3 (8 left + 8 up samples).
module tb_cs_neighbor_avg;

    localparam int unsigned DW = 8;
    localparam int unsigned BL = 3;
    // Edges counted from the start-sampling edge (=1) to the edge raising
    // avg_valid; the start cycle through the pulse cycle spans 19 cycles.
    localparam int NOGAP_EDGES = 18;
    localparam int BUDGET      = 100;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          flush;
    logic [DW-1:0] sample_in;
    logic          sample_valid;
    logic          sample_ready;
    logic          busy;
    logic          avg_valid;
    logic [DW-1:0] avg_y_left_out;
    logic [DW-1:0] avg_y_up_out;
    logic [DW-1:0] avg_y_dc_out;

    int errors = 0;
    int checks = 0;
    logic [DW-1:0] blk [16];

    cs_neighbor_avg #(.DATA_WIDTH(DW), .BLK_LOG2(BL)) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .flush          (flush),
        .sample_in      (sample_in),
        .sample_valid   (sample_valid),
        .sample_ready   (sample_ready),
        .busy           (busy),
        .avg_valid      (avg_valid),
        .avg_y_left_out (avg_y_left_out),
        .avg_y_up_out   (avg_y_up_out),
        .avg_y_dc_out   (avg_y_dc_out)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Left samples l_base + i*l_step, up samples u_base + i*u_step
    task automatic fill(input int l_base, input int l_step, input int u_base, input int u_step);
        for (int i = 0; i < 8; i++) begin
            blk[i]     = DW'(l_base + i * l_step);
            blk[i + 8] = DW'(u_base + i * u_step);
        end
    endtask

    task automatic check_avgs(input string tag, input int l, input int u, input int dc);
        check_val({tag, "_left"}, int'(avg_y_left_out), l);
        check_val({tag, "_up"},   int'(avg_y_up_out), u);
        check_val({tag, "_dc"},   int'(avg_y_dc_out), dc);
    endtask

    // One block; gaps gives valid pattern 1,0,0,...; restart pulses start mid-ACC_UP
    task automatic run_block(input bit gaps, input bit restart, output int edges);
        int idx;
        int ph;
        start = 1'b1;
        tick();
        start = 1'b0;
        edges = 1;
        idx   = 0;
        ph    = 0;
        check_val("ready_in_acc", int'(sample_ready), 1);
        check_val("busy_in_acc", int'(busy), 1);
        while (idx < 16 && edges < BUDGET) begin
            sample_valid = gaps ? (ph % 3 == 0) : 1'b1;
            sample_in    = sample_valid ? blk[idx] : 8'hEE;
            start        = restart && (idx == 12);
            tick();
            edges++;
            ph++;
            if (sample_valid) idx++;
        end
        start = 1'b0;
        // Offered while in CALC/DONE; must be ignored
        sample_valid = 1'b1;
        sample_in    = 8'hFF;
        while (!avg_valid && edges < BUDGET) begin
            tick();
            edges++;
        end
        sample_valid = 1'b0;
    endtask

    task automatic after_pulse(input string tag);
        tick();
        check_val({tag, "_pulse_len"}, int'(avg_valid), 0);
        check_val({tag, "_idle"}, int'(busy), 0);
    endtask

    initial begin
        int edges;
        int pulses;
        reset        = 1'b1;
        start        = 1'b0;
        flush        = 1'b0;
        sample_valid = 1'b0;
        sample_in    = '0;
        repeat (3) tick();
        check_val("rst_ready", int'(sample_ready), 0);
        check_val("rst_busy", int'(busy), 0);
        check_val("rst_valid", int'(avg_valid), 0);
        check_avgs("rst", 0, 0, 0);
        reset = 1'b0;
        tick();

        // Uniform block
        fill(10, 0, 20, 0);
        run_block(1'b0, 1'b0, edges);
        check_val("uni_latency", edges, NOGAP_EDGES);
        check_avgs("uni", 10, 20, 15);
        after_pulse("uni");

        // Rounding: 28+4>>3=4, 2040+4>>3=255, 2068+8>>4=129
        fill(0, 1, 255, 0);
        run_block(1'b0, 1'b0, edges);
        check_val("rnd_latency", edges, NOGAP_EDGES);
        check_avgs("rnd", 4, 255, 129);
        after_pulse("rnd");

        // Maximum values, no wrap
        fill(255, 0, 255, 0);
        run_block(1'b0, 1'b0, edges);
        check_avgs("max", 255, 255, 255);
        after_pulse("max");

        // Gaps: 15 inter-sample gaps of 2 idle cycles; junk offered in IDLE first
        fill(10, 0, 20, 0);
        sample_valid = 1'b1;
        sample_in    = 8'hFF;
        repeat (3) tick();
        check_avgs("idle_junk", 255, 255, 255);
        run_block(1'b1, 1'b0, edges);
        check_val("gap_latency", edges, NOGAP_EDGES + 30);
        check_avgs("gap", 10, 20, 15);
        after_pulse("gap");

        // Start while busy is ignored
        fill(40, 0, 60, 0);
        run_block(1'b0, 1'b1, edges);
        check_val("restart_latency", edges, NOGAP_EDGES);
        check_avgs("restart", 40, 60, 50);
        after_pulse("restart");

        // Start together with flush in IDLE: stays idle
        start = 1'b1;
        flush = 1'b1;
        tick();
        start = 1'b0;
        flush = 1'b0;
        check_val("start_flush_busy", int'(busy), 0);

        // Flush after 5 left samples, plus a same-cycle sample that is discarded
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            sample_valid = 1'b1;
            sample_in    = 8'd200;
            tick();
        end
        flush = 1'b1;
        tick();
        flush        = 1'b0;
        sample_valid = 1'b0;
        check_val("flush_busy", int'(busy), 0);
        check_val("flush_ready", int'(sample_ready), 0);
        pulses = 0;
        repeat (25) begin
            tick();
            if (avg_valid) pulses++;
        end
        check_val("flush_no_pulse", pulses, 0);
        check_avgs("flush_hold", 40, 60, 50);
        fill(0, 1, 255, 0);
        run_block(1'b0, 1'b0, edges);
        check_val("post_flush_latency", edges, NOGAP_EDGES);
        check_avgs("post_flush", 4, 255, 129);
        after_pulse("post_flush");

        // Asynchronous reset after 12 samples
        fill(255, 0, 255, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 12; i++) begin
            sample_valid = 1'b1;
            sample_in    = 8'd255;
            tick();
        end
        sample_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check_val("async_rst_busy", int'(busy), 0);
        check_val("async_rst_ready", int'(sample_ready), 0);
        check_avgs("async_rst", 0, 0, 0);
        tick();
        reset = 1'b0;
        tick();
        fill(10, 0, 20, 0);
        run_block(1'b0, 1'b0, edges);
        check_val("post_rst_latency", edges, NOGAP_EDGES);
        check_avgs("post_rst", 10, 20, 15);
        after_pulse("post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
